lz77_decoder: RTL and testbench

LZ77_DECODER -- requirements
Module: lz77_decoder

---
 rtl/lz77_decoder.sv | 165 ++++++++++++++++
 tb/tb_lz77_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_decoder.sv
// ---------------------------------------------------------------------------
// lz77_decoder
//
// Decodes an LZ77 stream of {offset, match_len, char_nxt} triples into a
// stream of characters, one per clock. A nine-entry search buffer holds the
// most recently emitted characters. sb[8] is the newest and sb[0] the oldest.
// After reset the buffer is filled with END_SGN. A literal equal to END_SGN
// marks the end of the stream. That literal is never emitted, and the block
// then parks in DONE until reset.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   code_valid  triple on offset/match_len/char_nxt is valid
//   offset      match distance, 0 = newest buffered char, 8 = oldest
//   match_len   number of chars copied from the buffer, 0-7
//   char_nxt    literal emitted after the copy
//   code_ready  block accepts a triple this cycle (state IDLE)
//   out_valid   char_out carries one decoded char
//   char_out    decoded char, holds its value while out_valid = 0
//   encode      constant 0, the block only decodes
//   finish      end-of-stream literal has been seen
// ---------------------------------------------------------------------------
module lz77_decoder #(
    parameter int          SEARCH_LEN = 9,
    parameter logic [7:0]  END_SGN    = 8'h24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [3:0] offset,
    input  logic [2:0] match_len,
    input  logic [7:0] char_nxt,
    output logic       code_ready,
    output logic       out_valid,
    output logic [7:0] char_out,
    output logic       encode,
    output logic       finish
);

    localparam int         NEWEST     = SEARCH_LEN - 1;
    localparam logic [3:0] NEWEST_IDX = 4'(NEWEST);

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] off_q, off_d;
    logic [2:0] len_q, len_d;
    logic [7:0] lit_q, lit_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] char_out_q, char_out_d;
    logic       finish_q, finish_d;

    logic [7:0] sb_q [SEARCH_LEN];
    logic [7:0] sb_d [SEARCH_LEN];

    logic       shift_en;
    logic [7:0] shift_in;
    logic [3:0] rd_idx;
    logic [7:0] copy_char;

    // The offset is clamped at accept time, so rd_idx always lands in 0..NEWEST.
    assign rd_idx    = NEWEST_IDX - off_q;
    assign copy_char = sb_q[rd_idx];

    // The buffer shift moves every entry one place toward index 0 and loads
    // the new char at the newest slot. Because a copy re-reads the same index
    // after each shift, an overlapping copy reproduces its own output.
    generate
        for (genvar gi = 0; gi < NEWEST; gi++) begin : g_sb_shift
            assign sb_d[gi] = shift_en ? sb_q[gi+1] : sb_q[gi];
        end
    endgenerate
    assign sb_d[NEWEST] = shift_en ? shift_in : sb_q[NEWEST];

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        len_d       = len_q;
        lit_d       = lit_q;
        out_valid_d = 1'b0;
        char_out_d  = char_out_q;
        finish_d    = finish_q;
        shift_en    = 1'b0;
        shift_in    = copy_char;

        case (state_q)
            IDLE: begin
                if (code_valid) begin
                    off_d   = (offset > NEWEST_IDX) ? NEWEST_IDX : offset;
                    len_d   = match_len;
                    lit_d   = char_nxt;
                    state_d = (match_len != 3'd0) ? COPY : LIT;
                end
            end
            COPY: begin
                out_valid_d = 1'b1;
                char_out_d  = copy_char;
                shift_en    = 1'b1;
                shift_in    = copy_char;
                len_d       = len_q - 3'd1;
                if (len_q == 3'd1) begin
                    state_d = LIT;
                end
            end
            LIT: begin
                if (lit_q != END_SGN) begin
                    out_valid_d = 1'b1;
                    char_out_d  = lit_q;
                    shift_en    = 1'b1;
                    shift_in    = lit_q;
                    state_d     = IDLE;
                end else begin
                    // End marker: nothing is emitted and the buffer is left untouched.
                    finish_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                finish_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            off_q       <= 4'd0;
            len_q       <= 3'd0;
            lit_q       <= 8'd0;
            out_valid_q <= 1'b0;
            char_out_q  <= 8'd0;
            finish_q    <= 1'b0;
            for (int i = 0; i < SEARCH_LEN; i++) begin
                sb_q[i] <= END_SGN;
            end
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            len_q       <= len_d;
            lit_q       <= lit_d;
            out_valid_q <= out_valid_d;
            char_out_q  <= char_out_d;
            finish_q    <= finish_d;
            for (int i = 0; i < SEARCH_LEN; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign code_ready = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign char_out   = char_out_q;
    assign encode     = 1'b0;
    assign finish     = finish_q;

endmodule

// File: tb/tb_lz77_decoder.sv
// ---------------------------------------------------------------------------
// tb_lz77_decoder
//
// Testbench for lz77_decoder. When a triple is driven, a reference model of
// the search buffer computes the chars that triple must produce and queues
// them. A monitor pops the queue on every out_valid and compares the char.
// Timing, reset, clamp and end-of-stream behaviour are checked directly.
// ---------------------------------------------------------------------------
module tb_lz77_decoder;

    logic       clk;
    logic       reset;
    logic       code_valid;
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_nxt;
    logic       code_ready;
    logic       out_valid;
    logic [7:0] char_out;
    logic       encode;
    logic       finish;

    lz77_decoder #(
        .SEARCH_LEN (9),
        .END_SGN    (8'h24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .offset     (offset),
        .match_len  (match_len),
        .char_nxt   (char_nxt),
        .code_ready (code_ready),
        .out_valid  (out_valid),
        .char_out   (char_out),
        .encode     (encode),
        .finish     (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] m_sb [9];
    logic [7:0] last_exp = 8'd0;
    longint     first_out_t = -1;
    longint     t_acc = 0;
    int         busy;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples just after each rising edge.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (reset) begin
            last_exp = 8'd0;
        end else if (out_valid) begin
            if (first_out_t < 0) first_out_t = $time - 1;
            if (exp_q.size() == 0) begin
                chk_val("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk_val("char_out", 32'(char_out), 32'(e));
                $display("out char %02h expected %02h", char_out, e);
                last_exp = e;
            end
        end else begin
            chk_val("char_hold", 32'(char_out), 32'(last_exp));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_sb[i] = 8'h24;
        exp_q.delete();
    endtask

    task automatic model_shift(input logic [7:0] c);
        for (int i = 0; i < 8; i++) m_sb[i] = m_sb[i+1];
        m_sb[8] = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_val("rst_out_valid", 32'(out_valid), 0);
        chk_val("rst_finish", 32'(finish), 0);
        chk_val("rst_code_ready", 32'(code_ready), 1);
        chk_val("rst_char_out", 32'(char_out), 0);
        $display("reset applied");
    endtask

    // Wait for IDLE; busy counts the negedges seen with code_ready low.
    task automatic wait_ready(output int nbusy);
        nbusy = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (code_ready) return;
            nbusy++;
        end
        chk_val("ready_timeout", 0, 1);
    endtask

    // Drive one triple, queue its expected chars, return after the accept edge.
    task automatic send(input logic [3:0] off, input logic [2:0] len, input logic [7:0] ch);
        int o;
        logic [7:0] c;
        int nb;
        if (!code_ready) wait_ready(nb);
        o = (off > 4'd8) ? 8 : int'(off);
        for (int k = 0; k < int'(len); k++) begin
            c = m_sb[8-o];
            exp_q.push_back(c);
            model_shift(c);
        end
        if (ch != 8'h24) begin
            exp_q.push_back(ch);
            model_shift(ch);
        end
        offset     = off;
        match_len  = len;
        char_nxt   = ch;
        code_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1;
        code_valid = 1'b0;
        $display("triple off=%0d len=%0d ch=%02h accepted", off, len, ch);
    endtask

    task automatic send_wait(input logic [3:0] off, input logic [2:0] len, input logic [7:0] ch);
        int nb;
        send(off, len, ch);
        wait_ready(nb);
        chk_val("drained", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rc;
        reset      = 1'b1;
        code_valid = 1'b0;
        offset     = 4'd0;
        match_len  = 3'd0;
        char_nxt   = 8'd0;
        do_reset();
        chk_val("encode", 32'(encode), 0);

        // Single literal and its latency
        first_out_t = -1;
        send(4'd0, 3'd0, 8'h41);
        wait_ready(busy);
        chk_val("latency", int'(first_out_t - t_acc), 10);
        chk_val("lit_occupancy", busy + 1, 2);
        chk_val("drained", exp_q.size(), 0);

        // Copy from history
        send_wait(4'd0, 3'd0, 8'h42);
        send_wait(4'd0, 3'd0, 8'h43);
        send_wait(4'd2, 3'd3, 8'h44);

        // Overlapping copy
        send_wait(4'd0, 3'd0, 8'h78);
        send(4'd0, 3'd7, 8'h79);
        wait_ready(busy);
        chk_val("overlap_occupancy", busy + 1, 9);
        chk_val("drained", exp_q.size(), 0);

        // Offset clamp
        send_wait(4'd12, 3'd1, 8'h6b);
        send_wait(4'd15, 3'd2, 8'h6c);

        // Random triples
        for (int n = 0; n < 20; n++) begin
            rc = 8'($urandom_range(32, 126));
            if (rc == 8'h24) rc = 8'h25;
            send_wait(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rc);
        end

        // Initial buffer contents
        do_reset();
        send_wait(4'd8, 3'd2, 8'h5a);

        // Reset during a copy
        do_reset();
        send(4'd1, 3'd5, 8'h51);
        @(negedge clk);
        @(negedge clk);
        do_reset();
        send_wait(4'd8, 3'd1, 8'h52);

        // End of stream
        send(4'd0, 3'd0, 8'h24);
        @(negedge clk);
        chk_val("end_finish_early", 32'(finish), 0);
        @(negedge clk);
        chk_val("end_finish", 32'(finish), 1);
        chk_val("end_code_ready", 32'(code_ready), 0);
        offset     = 4'd0;
        match_len  = 3'd0;
        char_nxt   = 8'h41;
        code_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk_val("done_finish", 32'(finish), 1);
            chk_val("done_code_ready", 32'(code_ready), 0);
            chk_val("done_out_valid", 32'(out_valid), 0);
        end
        code_valid = 1'b0;
        chk_val("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
